// File: rtl/mem_handle_pkg.sv
// mem_handle_pkg: shared widths, FSM states and per-channel handle state for mem_handle_arbiter
package mem_handle_pkg;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] rbegin;
    logic [ADDR_W-1:0] rend;
    logic [ADDR_W-1:0] ptr;
    logic              configured;
  } ch_cfg_t;
endpackage

// File: rtl/mem_handle_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the lowest requesting index at or after base
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   base,
  output logic [CH_W-1:0]   grant,
  output logic              valid
);
  logic [CH_W-1:0] idx;
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(base) + k) % NUM_CH);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_handle_arbiter.sv
// mem_handle_arbiter: NUM_CH region-bounded auto-increment handles sharing one memory port round-robin
module mem_handle_arbiter
  import mem_handle_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_SIZE = ADDR_W,
  parameter int DATA_SIZE = DATA_W,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             cfg_load,
  input  logic [NUM_CH*ADDR_SIZE-1:0]   cfg_begin,
  input  logic [NUM_CH*ADDR_SIZE-1:0]   cfg_end,
  input  logic [NUM_CH-1:0]             auto_inc,
  input  logic [NUM_CH-1:0]             r_en,
  input  logic [NUM_CH-1:0]             w_en,
  input  logic [NUM_CH*DATA_SIZE-1:0]   data_store,
  output logic [NUM_CH-1:0]             avail,
  output logic [NUM_CH-1:0]             done,
  output logic [NUM_CH-1:0]             wrap,
  output logic [NUM_CH-1:0]             cfg_err,
  output logic [NUM_CH*DATA_SIZE-1:0]   data_load,
  output logic [NUM_CH*ADDR_SIZE-1:0]   ptr,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_SIZE-1:0]          mem_addr,
  output logic [DATA_SIZE-1:0]          mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_SIZE-1:0]          mem_rdata
);
  state_t                 state, state_nx;
  ch_cfg_t                cfg_q [NUM_CH];
  logic [CH_W-1:0]        ch, rr, gnt;
  logic                   gv, we_q, at_end;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [DATA_SIZE-1:0]   wdata_q;
  logic [NUM_CH-1:0]      cfg_vec, busy, gnt_oh, elig;

  // a load on a channel this cycle masks its request so the load wins
  assign elig = cfg_vec & (r_en | w_en) & ~cfg_load;
  assign avail = cfg_vec & ~busy & ~gnt_oh;
  assign mem_req = (state == ISSUE) | (state == WAIT);
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign at_end = cfg_q[ch].ptr == cfg_q[ch].rend;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req  (elig),
    .base (rr),
    .grant(gnt),
    .valid(gv)
  );

  always_comb begin
    cfg_vec = '0;
    ptr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_vec[i] = cfg_q[i].configured;
      ptr[i*ADDR_SIZE +: ADDR_SIZE] = cfg_q[i].ptr;
    end
  end

  always_comb begin
    busy = '0;
    gnt_oh = '0;
    busy[ch] = state != IDLE;
    gnt_oh[gnt] = (state == IDLE) & gv;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:        state_nx = gv ? ISSUE : IDLE;
      ISSUE, WAIT: state_nx = mem_ack ? DONE : WAIT;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ch <= '0;
      rr <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      done <= '0;
      wrap <= '0;
      cfg_err <= '0;
      data_load <= '0;
      for (int i = 0; i < NUM_CH; i++) cfg_q[i] <= '0;
    end else begin
      state <= state_nx;
      done <= '0;
      wrap <= '0;
      cfg_err <= '0;
      if (state == IDLE && gv) begin
        ch <= gnt;
        we_q <= w_en[gnt];
        addr_q <= cfg_q[gnt].ptr;
        wdata_q <= data_store[int'(gnt)*DATA_SIZE +: DATA_SIZE];
      end
      // completion bookkeeping lands on the ack edge so it is visible during DONE
      if (mem_req && mem_ack) begin
        done <= NUM_CH'(1) << ch;
        rr <= (int'(ch) == NUM_CH - 1) ? '0 : ch + 1'b1;
        if (!we_q) data_load[int'(ch)*DATA_SIZE +: DATA_SIZE] <= mem_rdata;
        if (auto_inc[ch]) begin
          wrap <= at_end ? NUM_CH'(1) << ch : '0;
          cfg_q[ch].ptr <= at_end ? cfg_q[ch].rbegin : cfg_q[ch].ptr + 1'b1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_load[i] && !busy[i]) begin
          if (cfg_end[i*ADDR_SIZE +: ADDR_SIZE] < cfg_begin[i*ADDR_SIZE +: ADDR_SIZE]) cfg_err[i] <= 1'b1;
          else cfg_q[i] <= '{rbegin: cfg_begin[i*ADDR_SIZE +: ADDR_SIZE], rend: cfg_end[i*ADDR_SIZE +: ADDR_SIZE],
                             ptr: cfg_begin[i*ADDR_SIZE +: ADDR_SIZE], configured: 1'b1};
        end
      end
    end
  end
endmodule
